// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared key count, note codes, encoder states and note helpers
package piano_pkg;

    localparam int KEY_NUM = 7;
    localparam int NOTE_W  = 4;
    localparam int IDX_W   = 3;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_DO   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_RE   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_MI   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_FA   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_SOL  = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_LA   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_TI   = 4'd7;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] highest_index(input logic [KEY_NUM-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [NOTE_W-1:0] index_to_note(input logic [IDX_W-1:0] idx);
        logic [NOTE_W-1:0] code;
        case (idx)
            3'd0:    code = NOTE_DO;
            3'd1:    code = NOTE_RE;
            3'd2:    code = NOTE_MI;
            3'd3:    code = NOTE_FA;
            3'd4:    code = NOTE_SOL;
            3'd5:    code = NOTE_LA;
            3'd6:    code = NOTE_TI;
            default: code = NOTE_REST;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - single-key 2-flop synchroniser and stable-level debounce counter
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            level       <= 1'b0;
            cnt         <= '0;
        end else begin
            sync_meta   <= raw;
            sync_stable <= sync_meta;
            // any return to the held level restarts the stability window
            if (sync_stable == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_stable;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_debounce_encoder.sv
// rtl/key_debounce_encoder.sv - debounced 7-key last-pressed note encoder; KEY_REPEAT_EN adds auto-repeat
module key_debounce_encoder
    import piano_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_NUM-1:0] keys,
    input  logic [1:0]         octave,
    output logic [KEY_NUM-1:0] held_keys,
    output logic [NOTE_W-1:0]  note,
    output logic               note_on,
    output logic               note_off,
    output logic [1:0]         octave_out
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("key_debounce_encoder: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 2");
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (keys[i]),
            .level(held_keys[i])
        );
    end

    logic [KEY_NUM-1:0] held_prev;
    logic [KEY_NUM-1:0] rise;
    logic [KEY_NUM-1:0] fall;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   active_idx;
    logic [IDX_W-1:0]   idx_next;
    logic [NOTE_W-1:0]  note_next;
    logic               on_next;
    logic               off_next;
    logic [1:0]         oct_next;
    logic               repeat_due;

    assign rise = held_keys & ~held_prev;
    assign fall = ~held_keys & held_prev;

`ifdef KEY_REPEAT_EN
    localparam int unsigned      REP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] repeat_cnt;

    // counts cycles since the last onset while a key is sounding
    always_ff @(posedge clk) begin
        if (reset || state != ST_ACTIVE || on_next) begin
            repeat_cnt <= '0;
        end else begin
            repeat_cnt <= repeat_cnt + 1'b1;
        end
    end

    assign repeat_due = (state == ST_ACTIVE) && (repeat_cnt == REP_LAST);
`else
    assign repeat_due = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            held_prev  <= '0;
            state      <= ST_IDLE;
            active_idx <= '0;
            note       <= NOTE_REST;
            note_on    <= 1'b0;
            note_off   <= 1'b0;
            octave_out <= 2'd0;
        end else begin
            held_prev  <= held_keys;
            state      <= state_next;
            active_idx <= idx_next;
            note       <= note_next;
            note_on    <= on_next;
            note_off   <= off_next;
            octave_out <= oct_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = active_idx;
        note_next  = note;
        on_next    = 1'b0;
        off_next   = 1'b0;
        oct_next   = octave_out;
        case (state)
            ST_IDLE: begin
                if (|rise) begin
                    state_next = ST_ACTIVE;
                    idx_next   = highest_index(rise);
                    on_next    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // a new press outranks the release of the sounding key
                if (|rise) begin
                    idx_next = highest_index(rise);
                    on_next  = 1'b1;
                end else if (fall[active_idx]) begin
                    if (|held_keys) begin
                        idx_next = highest_index(held_keys);
                        on_next  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        note_next  = NOTE_REST;
                        off_next   = 1'b1;
                    end
                end else if (repeat_due) begin
                    on_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (on_next) begin
            note_next = index_to_note(idx_next);
            oct_next  = octave;
        end
    end

endmodule

// File: doc/key_debounce_encoder.md
Name: key_debounce_encoder

Overview:
- Front-end stage directly upstream of the piano Controller.
- Synchronises and debounces the 7 raw piano keys, then resolves them to a single note code using last-pressed priority.
- Emits one-cycle note_on/note_off events and latches the octave at each note onset.
- The Controller consumes note, note_on, note_off and octave_out in place of raw keys/octave.

Parameters:
DEBOUNCE_CYCLES, 2000000, consecutive stable cycles required to accept a key level change (20 ms at 100 MHz); minimum 2.
REPEAT_CYCLES, 25000000, auto-repeat period in cycles; used only when KEY_REPEAT_EN is defined.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
keys  input  7  raw asynchronous key switches, bit i = note i+1 (do..ti)
octave  input  2  raw octave selector, sampled only at note onset
held_keys  output  7  debounced key levels
note  output  4  active note: 0 = rest, 1..7 = key index+1
note_on  output  1  one-cycle pulse when note becomes or changes to a non-zero value
note_off  output  1  one-cycle pulse when note returns to 0
octave_out  output  2  octave captured in the cycle that note_on asserts

Behaviour:
- Reset (synchronous, reset=1 at a clk edge): synchroniser flops, held_keys, all debounce counters, note, note_on, note_off and octave_out go to 0. State returns to IDLE. Reset mid-debounce discards partial counts.
- Synchroniser: 2 flops per key; no logic is applied to the first stage.
- Debounce, per key:
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - If the synchronised value equals held_keys[i], the counter clears.
  - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1 while the value still differs, held_keys[i] takes the new value and the counter clears.
  - Any glitch back to the held level clears the counter.
- Edge detection: rise[i] and fall[i] are derived from held_keys versus its previous value.
- State machine, evaluated in the cycle after held_keys updates:
  - IDLE to ACTIVE on any rise. active index = highest-index rising key; note = index+1; note_on=1; octave_out <= octave.
  - ACTIVE on any rise: switch to the highest-index rising key. This applies even if the current key is still held; note_on pulses again.
  - ACTIVE, no rise, active key falls, other keys still held: fall back to the highest-index held key. note updates and note_on pulses.
  - ACTIVE, no rise, active key falls, no keys held: note=0, note_off=1, go to IDLE.
  - Falls of non-active keys: no output event.
  - Simultaneous rise and fall of the active key: the rise wins.
- note_on and note_off are never asserted together, and each is high for exactly one cycle.
- Latency: raw key edge to note/note_on = DEBOUNCE_CYCLES+3 clk edges (2 sync + DEBOUNCE_CYCLES + 1 encode).
- octave_out holds its value while note=0.

Optional Feature:
- KEY_REPEAT_EN defined:
  - A repeat counter (width $clog2(REPEAT_CYCLES)) clears on every note_on.
  - While in ACTIVE with the same active key, note_on re-pulses every REPEAT_CYCLES cycles, and octave_out is resampled on each repeat.
  - The counter clears on IDLE or reset.
- KEY_REPEAT_EN not defined: no repeat counter is built, and note_on occurs only on the events listed above.

Decomposition:
- Shared package piano_pkg holds:
  - KEY_NUM=7 and NOTE_W=4.
  - NOTE_REST=4'd0 and note codes NOTE_DO..NOTE_TI (1..7).
  - The state encoding for IDLE and ACTIVE.
- Sub-module key_debounce: single-bit 2-flop synchroniser plus counter. It takes DEBOUNCE_CYCLES and outputs the stable level. It is instantiated KEY_NUM times via generate.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10):
- Reset: hold reset 3 cycles with keys=7'h7F, then release -> all outputs 0. After release, the first note_on arrives no sooner than DEBOUNCE_CYCLES+3 edges.
- Single press: keys 0 to 7'b0000100, octave=2 -> note=3, note_on pulse and octave_out=2 exactly 7 edges after the change. Release -> note=0 and note_off pulse 7 edges later.
- Glitch rejection: keys[0] high for 3 cycles, then low -> held_keys, note and note_on stay 0.
- Priority and fallback:
  - Press key1 (note=2), then key5 (note=6, second note_on).
  - Release key5 -> note=2 with a note_on pulse, no note_off.
  - Release key1 -> note=0 with a note_off pulse.
- Simultaneous press: keys 0 to 7'b1000001 in one cycle -> note=7 with a single note_on. Release key0 -> no event.
- KEY_REPEAT_EN: hold key2 for 35 cycles after onset -> note_on at onset+10, +20 and +30, with note=3 throughout. Without the macro -> a single note_on only.
